// File: rtl/card_draw_display_pkg.sv
// Shared constants for the card-draw source and seven-segment front end.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package card_draw_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex glyphs 0..F, indexed by code.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [3:0] CARD_MIN = 4'd1;
  localparam logic [3:0] CARD_MAX = 4'd13;
  localparam logic [3:0] CNT_WRAP = 4'd12;

  typedef enum logic {
    TURN_CARD  = 1'b0,
    TURN_COUNT = 1'b1
  } turn_e;

  // Splits 0..63 into {tens, ones} with a short repeated-subtract ladder.
  function automatic logic [7:0] to_dec(input logic [5:0] value);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = value;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/card_draw_display_seg7_digit.sv
// Single hex digit to active-low seven-segment pattern.
module seg7_digit
  import card_draw_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_TABLE[code];
  end

endmodule

// File: rtl/card_draw_display.sv
// Card-draw source (free-running counter latched on draw rising edge) and
// seven-segment decode of card, score and glyph.
module card_draw_display
  import card_draw_display_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       draw,
  input  logic       turn,
  input  logic [5:0] score,
  input  logic [3:0] glyph,
  output logic [3:0] card,
  output logic       drawn,
  output logic [6:0] card_tens,
  output logic [6:0] card_ones,
  output logic [6:0] score_tens,
  output logic [6:0] score_ones,
  output logic [6:0] glyph_seg
);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] card_q, card_d;
  logic       draw_q;
  logic       drawn_q;
  logic       fire;

  always_comb begin
    fire  = draw & ~draw_q;
    cnt_d = (cnt_q == CNT_WRAP) ? 4'd0 : cnt_q + 4'd1;
    // Both modes sample cnt before this edge's increment.
    if (turn == TURN_COUNT) begin
      card_d = {2'b00, cnt_q[1:0]};
    end else begin
      card_d = cnt_q + CARD_MIN;
    end
  end

  // draw_q tracks draw even in reset so a level held across release does not fire.
  always_ff @(posedge clock) begin
    draw_q <= draw;
    if (reset) begin
      cnt_q   <= 4'd0;
      card_q  <= 4'd0;
      drawn_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      drawn_q <= fire;
      if (fire) begin
        card_q <= card_d;
      end
    end
  end

  assign card  = card_q;
  assign drawn = drawn_q;

  logic [7:0] card_dec;
  logic [7:0] score_dec;
  logic [6:0] card_tens_seg;
  logic [6:0] score_tens_seg;

  always_comb begin
    card_dec  = to_dec({2'b00, card_q});
    score_dec = to_dec(score);
  end

  seg7_digit u_glyph (
    .code (glyph),
    .seg  (glyph_seg)
  );

  seg7_digit u_card_tens (
    .code (card_dec[7:4]),
    .seg  (card_tens_seg)
  );

  seg7_digit u_card_ones (
    .code (card_dec[3:0]),
    .seg  (card_ones)
  );

  seg7_digit u_score_tens (
    .code (score_dec[7:4]),
    .seg  (score_tens_seg)
  );

  seg7_digit u_score_ones (
    .code (score_dec[3:0]),
    .seg  (score_ones)
  );

  // Leading zero suppressed on the tens digit.
  always_comb begin
    card_tens  = (card_dec[7:4] == 4'd0) ? SEG_BLANK : card_tens_seg;
    score_tens = (score_dec[7:4] == 4'd0) ? SEG_BLANK : score_tens_seg;
  end

endmodule

// File: tb/tb_card_draw_display.sv
// Directed self-checking bench for card_draw_display.
module tb_card_draw_display;

  logic       clock;
  logic       reset;
  logic       draw;
  logic       turn;
  logic [5:0] score;
  logic [3:0] glyph;
  logic [3:0] card;
  logic       drawn;
  logic [6:0] card_tens;
  logic [6:0] card_ones;
  logic [6:0] score_tens;
  logic [6:0] score_ones;
  logic [6:0] glyph_seg;

  int checks;
  int fails;
  int edge_n;

  card_draw_display dut (
    .clock      (clock),
    .reset      (reset),
    .draw       (draw),
    .turn       (turn),
    .score      (score),
    .glyph      (glyph),
    .card       (card),
    .drawn      (drawn),
    .card_tens  (card_tens),
    .card_ones  (card_ones),
    .score_tens (score_tens),
    .score_ones (score_ones),
    .glyph_seg  (glyph_seg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    draw  = 1'b0;
    turn  = 1'b0;
    repeat (3) tick();
    reset  = 1'b0;
    edge_n = 0;
  endtask

  // Leaves the bench just before edge n, with draw still low.
  task automatic run_until_before(input int n);
    while (edge_n < n - 1) tick();
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1;
    draw  = 1'b0;
    turn  = 1'b0;
    repeat (3) tick();
    checks++;
    if (card !== 4'd0 || drawn !== 1'b0) begin
      fails++;
      $display("FAIL reset_state card=%0d drawn=%0b required card=0 drawn=0", card, drawn);
    end
    reset  = 1'b0;
    edge_n = 0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (drawn) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL idle_drawn pulses=%0d required 0", pulses);
    end
    checks++;
    if (card !== 4'd0 || card_tens !== 7'h7F || card_ones !== 7'h40) begin
      fails++;
      $display("FAIL idle_card card=%0d tens=%h ones=%h required 0/7f/40",
               card, card_tens, card_ones);
    end
  endtask

  task automatic test_card_mode();
    int pulses;
    apply_reset();
    run_until_before(5);
    draw = 1'b1;
    tick();
    checks++;
    if (card !== 4'd5 || drawn !== 1'b1) begin
      fails++;
      $display("FAIL card_edge5 card=%0d drawn=%0b required card=5 drawn=1", card, drawn);
    end
    checks++;
    if (card_ones !== 7'h12 || card_tens !== 7'h7F) begin
      fails++;
      $display("FAIL card5_seg tens=%h ones=%h required 7f/12", card_tens, card_ones);
    end
    pulses = 0;
    repeat (10) begin
      tick();
      if (drawn) pulses++;
    end
    checks++;
    if (pulses !== 0 || card !== 4'd5) begin
      fails++;
      $display("FAIL hold_draw pulses=%0d card=%0d required pulses=0 card=5", pulses, card);
    end
    draw = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    run_until_before(13);
    draw = 1'b1;
    tick();
    checks++;
    if (card !== 4'd13 || card_tens !== 7'h79 || card_ones !== 7'h30) begin
      fails++;
      $display("FAIL card_edge13 card=%0d tens=%h ones=%h required 13/79/30",
               card, card_tens, card_ones);
    end
    apply_reset();
    run_until_before(14);
    draw = 1'b1;
    tick();
    checks++;
    if (card !== 4'd1 || drawn !== 1'b1) begin
      fails++;
      $display("FAIL card_edge14 card=%0d drawn=%0b required card=1 drawn=1", card, drawn);
    end
    draw = 1'b0;
    tick();
    checks++;
    if (drawn !== 1'b0) begin
      fails++;
      $display("FAIL drawn_one_cycle drawn=%0b required 0", drawn);
    end
  endtask

  task automatic test_count_mode();
    apply_reset();
    turn = 1'b1;
    run_until_before(8);
    draw = 1'b1;
    tick();
    checks++;
    if (card !== 4'd3) begin
      fails++;
      $display("FAIL count_edge8 card=%0d required 3", card);
    end
    draw = 1'b0;
    turn = 1'b0;
    tick();
    tick();
    checks++;
    if (card !== 4'd3) begin
      fails++;
      $display("FAIL turn_no_effect card=%0d required 3", card);
    end
    turn = 1'b1;
    // Edge 18: cnt before increment = 17 mod 13 = 4.
    run_until_before(18);
    draw = 1'b1;
    tick();
    checks++;
    if (card !== 4'd0 || drawn !== 1'b1) begin
      fails++;
      $display("FAIL count_edge18 card=%0d drawn=%0b required card=0 drawn=1", card, drawn);
    end
    draw = 1'b0;
    turn = 1'b0;
    tick();
  endtask

  task automatic test_score();
    logic [5:0] vals  [4] = '{6'd9, 6'd21, 6'd34, 6'd63};
    logic [6:0] tens  [4] = '{7'h7F, 7'h24, 7'h30, 7'h02};
    logic [6:0] ones  [4] = '{7'h10, 7'h79, 7'h19, 7'h30};
    for (int i = 0; i < 4; i++) begin
      score = vals[i];
      #1;
      checks++;
      if (score_tens !== tens[i] || score_ones !== ones[i]) begin
        fails++;
        $display("FAIL score_%0d tens=%h ones=%h required %h/%h",
                 vals[i], score_tens, score_ones, tens[i], ones[i]);
      end
    end
  endtask

  task automatic test_glyph();
    logic [6:0] exp_seg [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    for (int i = 0; i < 16; i++) begin
      glyph = 4'(i);
      #1;
      checks++;
      if (glyph_seg !== exp_seg[i]) begin
        fails++;
        $display("FAIL glyph_%h seg=%h required %h", i, glyph_seg, exp_seg[i]);
      end
    end
  endtask

  task automatic test_reset_during_draw();
    apply_reset();
    run_until_before(5);
    draw = 1'b1;
    tick();
    draw = 1'b0;
    tick();
    checks++;
    if (card !== 4'd5) begin
      fails++;
      $display("FAIL pre_reset_card card=%0d required 5", card);
    end
    draw  = 1'b1;
    reset = 1'b1;
    tick();
    checks++;
    if (card !== 4'd0 || drawn !== 1'b0) begin
      fails++;
      $display("FAIL reset_vs_draw card=%0d drawn=%0b required card=0 drawn=0", card, drawn);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (card !== 4'd0 || drawn !== 1'b0) begin
      fails++;
      $display("FAIL draw_across_release card=%0d drawn=%0b required card=0 drawn=0",
               card, drawn);
    end
    draw = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    edge_n = 0;
    reset  = 1'b1;
    draw   = 1'b0;
    turn   = 1'b0;
    score  = 6'd0;
    glyph  = 4'd0;
    @(negedge clock);
    test_reset();
    test_card_mode();
    test_wrap();
    test_count_mode();
    test_score();
    test_glyph();
    test_reset_during_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/card_draw_display.md
# card_draw_display

Card-draw source and seven-segment display front end for the 21 card game. It runs a free-running card counter and latches a card value on each rising edge of a draw request, with two range modes: card face (1–13) or dealer draw count (0–3). It also converts the drawn card, a 6-bit score and a 4-bit glyph code into active-low seven-segment patterns. The block sits between the game control/datapath and the HEX displays.

## Interface
- No parameters; all widths and ranges are fixed.
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- draw  in  1  draw request level; a draw fires on its 0→1 transition.
- turn  in  1  range select: 0 = card mode (1..13), 1 = count mode (0..3).
- score  in  6  unsigned value 0..63, shown in decimal.
- glyph  in  4  hex code for the single-digit display.
- card  out  4  last latched card or count value.
- drawn  out  1  one-cycle pulse; high in the cycle after a draw fires.
- card_tens / card_ones  out  7 each  decimal digits of card.
- score_tens / score_ones  out  7 each  decimal digits of score.
- glyph_seg  out  7  hex pattern of glyph.

## Operation
- cnt: 4-bit free-running counter with range 0..12. It increments every non-reset clock and wraps from 12 to 0. It does not depend on draw or turn.
- draw_q: register that holds draw from the previous clock.
- A draw fires when draw=1 and draw_q=0 at an edge.
- When a draw fires with turn=0: card ← cnt+1, using cnt before its increment, so card is in 1..13.
- When a draw fires with turn=1: card ← {2'b00, cnt[1:0]}, so card is in 0..3.
- When no draw fires, card holds its value.
- Holding draw high produces exactly one draw. A new draw needs draw to return to 0 for at least one clock.
- Segment encoding is active-low, bit0=a … bit6=g.
- Glyph patterns: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex). Blank = 7F.
- Decimal pair for card (zero-extended to 6 bits) and for score:
  - tens = value/10, range 0..6.
  - ones = value%10.
  - tens is blank when value < 10; ones always shows a digit.
- All segment outputs are combinational from card, score and glyph.

## Timing
- Reset, applied at any edge including mid-sequence: cnt←0, card←0, drawn←0.
- During reset, draw_q ← draw. A draw held high across reset release therefore does not fire.
- Reset with a simultaneous draw edge: reset wins and no card is latched.
- After reset deasserts, the first non-reset edge is edge 1. cnt equals n mod 13 after edge n.
- A draw sampled at edge n (n≥1) in card mode gives card = ((n−1) mod 13)+1. card is valid and drawn=1 from edge n until edge n+1.
- Latency from draw rising to updated card: one clock edge. Segment outputs follow within the same cycle.
- A turn change has no effect until the next draw.

## Structure
- Shared package holds:
  - segment constants SEG_BLANK (7'h7F) and the 16-entry glyph table;
  - CARD_MIN=1, CARD_MAX=13, CNT_WRAP=12;
  - turn encodings TURN_CARD=0, TURN_COUNT=1.
- One natural sub-module: seg7_digit (4-bit code → 7-bit active-low pattern).
  - Instantiate it five times: glyph, card tens/ones, score tens/ones.
  - Tens-blank muxing stays in the top.
- Counter, edge detector and card register stay in the top.

## Test plan
- Reset 3 cycles, release, then hold draw low 20 cycles → card=0, drawn never high, card_tens=7F, card_ones=40. cnt wraps: 0 after edge 13.
- turn=0, raise draw just before edge 5 → card=5, drawn pulses exactly 1 cycle, card_ones=12. Holding draw 10 more cycles gives no second pulse.
- turn=0, draw edge at edge 13 → card=13, card_tens=79, card_ones=30. Draw edge at edge 14 → card=1.
- turn=1, draw edge at edge 8 (cnt=7) → card=3. Draw edge at edge 5 (cnt=4) → card=0.
- score sweep: 9 → tens 7F, ones 10; 21 → 24/79; 34 → 30/19; 63 → 02/30.
- glyph sweep: A→08, d→21, E→06, 0..F all match the table. Assert reset during a draw edge → card stays 0 and drawn stays 0.
